nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead adder cell.

---
 rtl/nibble_serial_adder.sv | 144 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit
//   carry-lookahead cell. An accepted operand pair is processed one nibble
//   per cycle, least significant nibble first. Each nibble's carry-out is
//   registered and becomes the carry-in of the next nibble.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair present
//   in_ready   block can accept an operand pair (high only in IDLE)
//   X, Y       operands A and B (WIDTH bits)
//   Cin        carry-in for add; ignored when Sub=1
//   Sub        1: compute X - Y as X + ~Y + 1
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   S          sum/difference, modulo 2^WIDTH
//   Cout       carry out of the MSB (for Sub: 1 = no borrow)
//   Ovf        two's-complement signed overflow
//
// Timing: operands accepted in cycle t, nibble k processed in cycle t+1+k,
// out_valid high from cycle t+N+1 (N = WIDTH/4).

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q;       // operand A
    logic [WIDTH-1:0] b_q;       // effective operand B' (inverted for subtract)
    logic             carry_q;   // carry into the current nibble
    logic [IW-1:0]    idx_q;     // nibble being processed

    logic [3:0]       a_nib, b_nib, cell_sum;
    logic             cell_cout;

    // 4-bit carry-lookahead cell: all carries from generate/propagate terms.
    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       c0);
        logic [3:0] g, p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];
    assign {cell_cout, cell_sum} = cla4(a_nib, b_nib, carry_q);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: the next-state default is assigned first so no path leaves
    // state_d unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)          state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // NOTE: the operand registers are reset along with the visible results;
    // they are only a few flops, and a defined value keeps the first
    // post-reset cycles free of X on the cell inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            S       <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= X;
                        b_q     <= Y ^ {WIDTH{Sub}};
                        carry_q <= Sub | Cin;   // subtract forces the +1
                        idx_q   <= '0;
                        S       <= '0;
                    end
                end
                RUN: begin
                    S[{idx_q, 2'b00} +: 4] <= cell_sum;
                    carry_q                <= cell_cout;
                    idx_q                  <= idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        Cout <= cell_cout;
                        // Same-sign operands producing a different-sign result.
                        Ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                (cell_sum[3] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16, N=4).
// An acceptance watcher pushes the reference result for every accepted
// operand pair; a separate monitor pops and compares on each result handshake
// and checks acceptance-to-out_valid latency.

module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X, Y;
    logic         Cin, Sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         Cout, Ovf;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    res_t exp_q[$];
    int   acc_q[$];
    bit   stream_mode = 1'b0;
    int   last_acc    = -1;
    bit   prev_v      = 1'b0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on the effective operands.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic cin, input logic sub);
        res_t         r;
        logic [W-1:0] bp;
        longint       c, u, sv;
        bp     = sub ? ~y : y;
        c      = (sub || cin) ? 1 : 0;
        u      = longint'(x) + longint'(bp) + c;
        sv     = longint'($signed(x)) + longint'($signed(bp)) + c;
        r.s    = u[W-1:0];
        r.cout = u[W];
        r.ovf  = (sv > 32767) || (sv < -32768);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Acceptance watcher: scoreboard push side.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(model(X, Y, Cin, Sub));
            acc_q.push_back(cyc);
            if (stream_mode && last_acc >= 0)
                check("accept_spacing", cyc - last_acc, N + 2);
            last_acc = cyc;
        end
    end

    // Output monitor: scoreboard pop side.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (acc_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL latency: out_valid with no accepted operation");
                end else begin
                    check("latency", cyc - acc_q.pop_front(), N + 1);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL result: result with empty scoreboard");
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("result_S", S, e.s);
                    check("result_Cout", Cout, e.cout);
                    check("result_Ovf", Ovf, e.ovf);
                end
            end
            prev_v = out_valid;
        end
    end

    // Wait at negedges for in_ready (want_out=0) or out_valid (want_out=1).
    task automatic wait_sig(input bit want_out, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (want_out ? out_valid : in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++; checks++;
            $display("FAIL timeout waiting for %s", want_out ? "out_valid" : "in_ready");
        end
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic cin, input logic sub);
        bit ok;
        X = x; Y = y; Cin = cin; Sub = sub; in_valid = 1'b1;
        wait_sig(1'b0, ok);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic cin, input logic sub, input bit chk,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        bit ok;
        issue(x, y, cin, sub);
        wait_sig(1'b1, ok);
        if (ok && chk) begin
            check("directed_S", S, es);
            check("directed_Cout", Cout, ec);
            check("directed_Ovf", Ovf, eo);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit   ok;
        res_t r;
        logic [W-1:0] bx, by;

        // Reset with in_valid high: nothing may be captured.
        rst = 1'b1; in_valid = 1'b1; X = 16'h1234; Y = 16'h1111;
        Cin = 1'b0; Sub = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_S", S, 0);
        check("rst_Cout", Cout, 0);
        check("rst_Ovf", Ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("no_capture_in_reset", in_ready, 1);
        @(posedge clk); #1;

        // Directed arithmetic cases.
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: result held while out_ready=0, new operands ignored.
        out_ready = 1'b0;
        bx = 16'($urandom); by = 16'($urandom);
        r  = model(bx, by, 1'b0, 1'b1);
        issue(bx, by, 1'b0, 1'b1);
        wait_sig(1'b1, ok);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            X = 16'($urandom); Y = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_S", S, r.s);
            check("bp_Cout", Cout, r.cout);
            check("bp_Ovf", Ovf, r.ovf);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        @(posedge clk); #1;

        // Back-to-back stream with in_valid held high.
        stream_mode = 1'b1; last_acc = -1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            X = 16'($urandom); Y = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
            wait_sig(1'b0, ok);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_sig(1'b1, ok);
        @(posedge clk); #1;
        stream_mode = 1'b0;

        // Reset during RUN at idx=2 aborts the operation.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);   // now in cycle processing idx 0
        @(posedge clk); #1;                      // idx 1
        @(posedge clk); #1;                      // idx 2
        rst = 1'b1; in_valid = 1'b1; X = 16'hAAAA; Y = 16'h5555;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete(); acc_q.delete();
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_S", S, 0);
        @(posedge clk); #1;
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);

        // Random operations, checked by the scoreboard.
        for (int k = 0; k < 8; k++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  1'b0, 16'h0000, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
